// File: rtl/time_ascii_sender.sv
// Formats a binary hour/min/sec snapshot as ASCII "HH:MM:SS[CR]LF" and streams it to uart_tx.
// Optional feature macro: TIME_TX_CRLF_EN (adds CR before the trailing LF).
module time_ascii_sender #(
  parameter logic [7:0]  SEP_CHAR     = 8'h3A,
  parameter int unsigned GUARD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_send,
  input  logic [4:0] i_hour,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  input  logic       i_tx_busy,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data,
  output logic       o_busy,
  output logic       o_done
);

  // Handshake with uart_tx: o_tx_start is a one-cycle strobe with o_tx_data valid in that
  // cycle; the transmitter raises i_tx_busy within GUARD_CYCLES and drops it when the byte
  // has left. The next byte is only issued once i_tx_busy is observed low.

`ifdef TIME_TX_CRLF_EN
  localparam logic [3:0] LAST = 4'd9;
`else
  localparam logic [3:0] LAST = 4'd8;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SEND  = 3'd2,
    GUARD = 3'd3,
    WAIT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t     state;
  logic       pending;
  logic [3:0] byte_idx;
  logic [3:0] guard_cnt;
  logic [4:0] hour_q;
  logic [5:0] min_q;
  logic [5:0] sec_q;
  logic [7:0] h_t, h_o, m_t, m_o, s_t, s_o;
  logic [7:0] frame_byte;

  function automatic logic [7:0] ascii_tens(input logic [5:0] v);
    return 8'h30 + 8'(v / 6'd10);
  endfunction

  function automatic logic [7:0] ascii_ones(input logic [5:0] v);
    return 8'h30 + 8'(v % 6'd10);
  endfunction

  always_comb begin
    frame_byte = 8'h0A;
    case (byte_idx)
      4'd0:    frame_byte = h_t;
      4'd1:    frame_byte = h_o;
      4'd2:    frame_byte = SEP_CHAR;
      4'd3:    frame_byte = m_t;
      4'd4:    frame_byte = m_o;
      4'd5:    frame_byte = SEP_CHAR;
      4'd6:    frame_byte = s_t;
      4'd7:    frame_byte = s_o;
`ifdef TIME_TX_CRLF_EN
      4'd8:    frame_byte = 8'h0D;
`endif
      default: frame_byte = 8'h0A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= 1'b0;
      byte_idx   <= 4'd0;
      guard_cnt  <= 4'd0;
      hour_q     <= 5'd0;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
      h_t        <= 8'h30;
      h_o        <= 8'h30;
      m_t        <= 8'h30;
      m_o        <= 8'h30;
      s_t        <= 8'h30;
      s_o        <= 8'h30;
      o_tx_start <= 1'b0;
      o_tx_data  <= 8'h00;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_done     <= 1'b0;
      // Requests arriving while a frame is in flight (including DONE) collapse into one.
      if (state != IDLE && i_send) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (i_send || pending) begin
            hour_q  <= i_hour;
            min_q   <= i_min;
            sec_q   <= i_sec;
            pending <= 1'b0;
            o_busy  <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          h_t      <= ascii_tens({1'b0, hour_q});
          h_o      <= ascii_ones({1'b0, hour_q});
          m_t      <= ascii_tens(min_q);
          m_o      <= ascii_ones(min_q);
          s_t      <= ascii_tens(sec_q);
          s_o      <= ascii_ones(sec_q);
          byte_idx <= 4'd0;
          state    <= SEND;
        end
        SEND: begin
          o_tx_start <= 1'b1;
          o_tx_data  <= frame_byte;
          guard_cnt  <= 4'(GUARD_CYCLES - 1);
          state      <= GUARD;
        end
        GUARD: begin
          if (guard_cnt == 4'd0) state <= WAIT;
          else                   guard_cnt <= guard_cnt - 4'd1;
        end
        WAIT: begin
          if (!i_tx_busy) begin
            if (byte_idx < LAST) begin
              byte_idx <= byte_idx + 4'd1;
              state    <= SEND;
            end else begin
              o_done <= 1'b1;
              o_busy <= 1'b0;
              state  <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
